seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
// Front-end controller for the serial pattern detector. Accepts parallel words on a valid/ready
// handshake and serialises them MSB-first, one bit per clock. Runs a programmable pattern match
// (default 101101) on the bit stream, counts matches and raises a sticky interrupt at a threshold.
// Sits between the word-oriented bus side and the bit-serial detection path.
// PARAMETERS
// DATA_W  8  width of in_data; bits per accepted word
// PAT_W   6  maximum pattern length in bits
// CNT_W   8  width of match_count
// PORTS
// clock          in   1       single clock, rising edge
// reset          in   1       asynchronous, active-low; all state cleared while low
// start          in   1       pulse: latch cfg_*, clear count/history, IDLE->ARMED
// stop           in   1       pulse: abort, any state->IDLE
// cfg_pattern    in   PAT_W   pattern; bit cfg_len-1 is the first bit expected
// cfg_len        in   3       pattern length 1..PAT_W; 0 or >PAT_W treated as PAT_W
// cfg_overlap    in   1       1: overlapping matches counted; 0: history restarts after a match
// cfg_threshold  in   CNT_W   irq level; 0 disables irq
// in_valid       in   1       word available
// in_data        in   DATA_W  word, shifted out MSB first
// in_ready       out  1       word accepted on clock edge when in_valid&in_ready
// bit_valid      out  1       bit_out carries a stream bit this cycle
// bit_out        out  1       current serial bit
// match          out  1       one-cycle pulse per detected pattern
// match_count    out  CNT_W   matches since start, saturating
// irq            out  1       sticky, set when match_count reaches cfg_threshold
// irq_clr        in   1       pulse: clear irq
// busy           out  1       state != IDLE
// BEHAVIOUR
// - Reset values: in_ready=0, bit_valid=0, bit_out=0, match=0, match_count=0, irq=0, busy=0, state IDLE.
// - States:
//   - IDLE: in_ready=0; start -> ARMED.
//   - ARMED: in_ready=1; on accept, load shifter with in_data, bit counter=0 -> SHIFT.
//   - SHIFT: bit_valid=1, bit_out=shifter MSB. Each edge shifts left and increments the bit counter.
//     On the last bit (counter=DATA_W-1), in_ready=1: an accepted word reloads the shifter and
//     SHIFT continues with no bubble; otherwise -> ARMED.
// - Config (pattern, len, overlap, threshold) is latched at start; changes while busy are ignored.
// - start in ARMED/SHIFT restarts: clears count, history, seen counter and irq; partial word
//   discarded; -> ARMED. stop in any state -> IDLE, partial word discarded; count and irq retained.
//   stop has priority over start in the same cycle.
// - Detection:
//   - On each SHIFT edge, history <= {history[PAT_W-2:0], bit_out}; seen counter saturates at PAT_W.
//   - match is registered: high in the cycle after the final pattern bit was on bit_out,
//     when seen>=len and history[len-1:0]==pattern[len-1:0].
//   - If cfg_overlap=0, a match sets seen=0 so the next match needs len fresh bits.
//   - History is not cleared between words; the stream is continuous across word boundaries.
// - match_count increments with each match pulse and holds at 2^CNT_W-1.
// - irq sets on the edge where match_count becomes equal to threshold (threshold!=0). It also
//   sets if already saturated at that value. irq stays set until irq_clr; set wins over a
//   simultaneous irq_clr.
// - Latency: word accepted at edge N -> first bit on bit_out in cycle N+1 -> match no earlier
//   than cycle N+1+len.
// TESTING
// - Reset low mid-SHIFT with count=3, irq=1 -> all outputs zero immediately; after release stays IDLE, in_ready=0.
// - start, pattern 101101 len 6, in_data=0xB6 -> bit_out 1,0,1,1,0,1,1,0; one match in shift cycle 7, count=1.
// - overlap=1, words 0xB6,0xC0 back-to-back -> bit_valid high 16 consecutive cycles, 2 matches (after bits 6 and 9).
// - overlap=0, same words -> exactly 1 match, count=1.
// - threshold=2, repeat 0xB6 three times -> irq set as count hits 2, stays through 3rd match; irq_clr clears it.
// - CNT_W=2, 5 matches -> count saturates at 3; stop mid-word -> IDLE, count=3 retained; start -> count=0.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Word-side valid/ready handshake feeding the serial pattern detector.
// The master offers words; the slave (the detector front end) accepts them.
interface seq_detect_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_detect_ctrl.sv
// Front-end controller for the serial pattern detector.
// Accepts parallel words on a valid/ready handshake, serialises them MSB-first
// one bit per clock, matches a programmable pattern on the bit stream, counts
// matches (saturating) and raises a sticky interrupt at a threshold.
module seq_detect_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 6,
  parameter int CNT_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [2:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_threshold,
  seq_detect_ctrl_if.slave word_if,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             irq,
  input  logic             irq_clr,
  output logic             busy
);

  localparam int BC_W   = $clog2(DATA_W);
  localparam int SEEN_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] shifter;
  logic [BC_W-1:0]   bit_cnt;
  logic [PAT_W-1:0]  history;
  logic [SEEN_W-1:0] seen;

  // Configuration captured at start; bus-side changes while busy are ignored.
  logic [PAT_W-1:0]  pat_q;
  logic [SEEN_W-1:0] len_q;
  logic              overlap_q;
  logic [CNT_W-1:0]  thresh_q;

  logic              word_accept;
  logic              last_bit;
  logic [SEEN_W-1:0] len_norm;
  logic [PAT_W-1:0]  pat_mask;
  logic [PAT_W-1:0]  hist_next;
  logic [SEEN_W-1:0] seen_inc;
  logic              hit;
  logic [CNT_W-1:0]  count_next;

  // The serial bit is simply the shifter MSB; the shifter is cleared whenever
  // the stream stops, so bit_out reads 0 outside SHIFT.
  assign bit_out = shifter[DATA_W-1];

  // Length normalisation, pattern mask and next-bit match evaluation.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    len_norm = SEEN_W'(PAT_W);
    if (cfg_len != 3'd0 && int'(cfg_len) <= PAT_W) len_norm = SEEN_W'(cfg_len);

    pat_mask = '0;
    for (int i = 0; i < PAT_W; i++) pat_mask[i] = (i < int'(len_q));

    word_accept = word_if.in_valid & word_if.in_ready;
    last_bit    = (bit_cnt == BC_W'(DATA_W - 1));
    hist_next   = {history[PAT_W-2:0], bit_out};
    seen_inc    = (seen == SEEN_W'(PAT_W)) ? seen : seen + 1'b1;
    hit         = (seen_inc >= len_q) && ((hist_next & pat_mask) == (pat_q & pat_mask));
    count_next  = (&match_count) ? match_count : match_count + 1'b1;
  end

  // Control FSM, serialiser, detector history, counter and irq in one process.
  // NOTE: sequential state uses non-blocking assignments only; within one
  // edge the last assignment to a register wins, which is how an irq set
  // overrides a simultaneous irq_clr below.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      shifter          <= '0;
      bit_cnt          <= '0;
      history          <= '0;
      seen             <= '0;
      pat_q            <= '0;
      len_q            <= '0;
      overlap_q        <= 1'b0;
      thresh_q         <= '0;
      word_if.in_ready <= 1'b0;
      bit_valid        <= 1'b0;
      match            <= 1'b0;
      match_count      <= '0;
      irq              <= 1'b0;
      busy             <= 1'b0;
    end else begin
      match <= 1'b0;
      if (irq_clr) irq <= 1'b0;

      if (stop) begin
        // Abort: partial word dropped, count and irq kept.
        state            <= IDLE;
        shifter          <= '0;
        word_if.in_ready <= 1'b0;
        bit_valid        <= 1'b0;
        busy             <= 1'b0;
      end else if (start) begin
        // (Re)start: latch config, clear detector and statistics.
        pat_q            <= cfg_pattern;
        len_q            <= len_norm;
        overlap_q        <= cfg_overlap;
        thresh_q         <= cfg_threshold;
        history          <= '0;
        seen             <= '0;
        match_count      <= '0;
        irq              <= 1'b0;
        shifter          <= '0;
        bit_cnt          <= '0;
        state            <= ARMED;
        word_if.in_ready <= 1'b1;
        bit_valid        <= 1'b0;
        busy             <= 1'b1;
      end else begin
        case (state)
          ARMED: begin
            if (word_accept) begin
              shifter          <= word_if.in_data;
              bit_cnt          <= '0;
              state            <= SHIFT;
              bit_valid        <= 1'b1;
              word_if.in_ready <= 1'b0;
            end
          end
          SHIFT: begin
            history <= hist_next;
            if (hit) begin
              match       <= 1'b1;
              match_count <= count_next;
              seen        <= overlap_q ? seen_inc : '0;
              if (thresh_q != '0 && count_next == thresh_q) irq <= 1'b1;
            end else begin
              seen <= seen_inc;
            end

            if (last_bit) begin
              if (word_accept) begin
                // Back-to-back word: reload with no bubble.
                shifter          <= word_if.in_data;
                bit_cnt          <= '0;
                word_if.in_ready <= 1'b0;
              end else begin
                shifter   <= shifter << 1;
                state     <= ARMED;
                bit_valid <= 1'b0;
              end
            end else begin
              shifter          <= shifter << 1;
              bit_cnt          <= bit_cnt + 1'b1;
              word_if.in_ready <= (bit_cnt == BC_W'(DATA_W - 2));
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: stimulus pushes expected serial bits
// and expected match events; an independent monitor pops and compares them.
module tb_seq_detect_ctrl;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 6;
  localparam int CNT_W  = 2;

  typedef struct {
    int         after_bits;
    logic [1:0] count;
    logic       irq;
  } match_exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [2:0]       cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_threshold = '0;
  logic             irq_clr = 1'b0;
  logic             bit_valid, bit_out, match, irq, busy;
  logic [CNT_W-1:0] match_count;

  seq_detect_ctrl_if #(.DATA_W(DATA_W)) word_bus ();

  seq_detect_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .cfg_pattern   (cfg_pattern),
    .cfg_len       (cfg_len),
    .cfg_overlap   (cfg_overlap),
    .cfg_threshold (cfg_threshold),
    .word_if       (word_bus),
    .bit_valid     (bit_valid),
    .bit_out       (bit_out),
    .match         (match),
    .match_count   (match_count),
    .irq           (irq),
    .irq_clr       (irq_clr),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad = 0;
  logic       exp_bits[$];
  match_exp_t exp_m[$];
  int         pushed_bits = 0;
  int         bits_seen = 0;
  int         gap_cnt = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [PAT_W-1:0] pat, input logic [2:0] len,
                          input logic ov, input logic [CNT_W-1:0] thr);
    cfg_pattern   = pat;
    cfg_len       = len;
    cfg_overlap   = ov;
    cfg_threshold = thr;
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  // Offer one word; push the first nbits of it as expected stream bits.
  task automatic send_word(input logic [DATA_W-1:0] data, input int nbits);
    logic accepted;
    accepted = 1'b0;
    word_bus.in_valid = 1'b1;
    word_bus.in_data  = data;
    for (int k = 0; k < nbits; k++) begin
      exp_bits.push_back(data[DATA_W-1-k]);
      pushed_bits++;
    end
    for (int c = 0; c < 64 && !accepted; c++) begin
      @(posedge clock);
      if (word_bus.in_ready) accepted = 1'b1;
      #1;
    end
    word_bus.in_valid = 1'b0;
    check("word_accept", accepted, 1);
  endtask

  task automatic expect_match(input int after_rel, input logic [1:0] cnt, input logic irq_v);
    match_exp_t e;
    e.after_bits = pushed_bits + after_rel;
    e.count      = cnt;
    e.irq        = irq_v;
    exp_m.push_back(e);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_bits.size() != 0 || exp_m.size() != 0) && c < 300) begin
      tick();
      c++;
    end
    check("drain_pending", exp_bits.size() + exp_m.size(), 0);
    repeat (3) tick();
  endtask

  // Monitor: compares DUT stream and match events against the scoreboard.
  initial begin
    logic       prev_valid;
    logic       eb;
    match_exp_t em;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (match === 1'b1) begin
        check("match_expected", int'(exp_m.size() > 0), 1);
        if (exp_m.size() > 0) begin
          em = exp_m.pop_front();
          check("match_pos", bits_seen, em.after_bits);
          check("match_count", match_count, em.count);
          check("match_irq", irq, em.irq);
        end
      end
      if (bit_valid === 1'b1) begin
        check("bit_expected", int'(exp_bits.size() > 0), 1);
        if (exp_bits.size() > 0) begin
          eb = exp_bits.pop_front();
          check("bit_out", bit_out, eb);
        end
        bits_seen++;
      end
      if (prev_valid && bit_valid !== 1'b1) gap_cnt++;
      prev_valid = (bit_valid === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int g0, b0;
    word_bus.in_valid = 1'b0;
    word_bus.in_data  = '0;

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_in_ready", word_bus.in_ready, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_bit_out", bit_out, 0);
    check("rst_match", match, 0);
    check("rst_count", match_count, 0);
    check("rst_irq", irq, 0);
    check("rst_busy", busy, 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    check("idle_in_ready", word_bus.in_ready, 0);

    // Single word 0xB6 against 101101: one match after bit 6.
    do_start(6'b101101, 3'd6, 1'b1, 2'd0);
    check("armed_busy", busy, 1);
    check("armed_in_ready", word_bus.in_ready, 1);
    g0 = gap_cnt; b0 = bits_seen;
    expect_match(6, 2'd1, 1'b0);
    send_word(8'hB6, 8);
    drain();
    check("t1_bits", bits_seen - b0, 8);
    check("t1_runs", gap_cnt - g0, 1);
    check("t1_count", match_count, 1);
    check("t1_rearmed", word_bus.in_ready, 1);

    // Overlap on, 0xB6 then 0xC0 back-to-back: one unbroken 16-bit run.
    do_start(6'b101101, 3'd6, 1'b1, 2'd0);
    check("restart_count", match_count, 0);
    g0 = gap_cnt; b0 = bits_seen;
    expect_match(6, 2'd1, 1'b0);
    expect_match(9, 2'd2, 1'b0);
    send_word(8'hB6, 8);
    send_word(8'hC0, 8);
    drain();
    check("t2_bits", bits_seen - b0, 16);
    check("t2_runs", gap_cnt - g0, 1);
    check("t2_count", match_count, 2);

    // Overlap off, same words: only the first match.
    do_start(6'b101101, 3'd6, 1'b0, 2'd0);
    expect_match(6, 2'd1, 1'b0);
    send_word(8'hB6, 8);
    send_word(8'hC0, 8);
    drain();
    check("t3_count", match_count, 1);

    // Threshold 2, overlap off, 0xB6 x3: matches after bits 6, 14, 22.
    do_start(6'b101101, 3'd6, 1'b0, 2'd2);
    expect_match(6,  2'd1, 1'b0);
    expect_match(14, 2'd2, 1'b1);
    expect_match(22, 2'd3, 1'b1);
    for (int w = 0; w < 3; w++) send_word(8'hB6, 8);
    drain();
    check("t4_irq_held", irq, 1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("t4_irq_cleared", irq, 0);
    check("t4_count", match_count, 3);

    // Saturation with 2-bit count, overlap on: matches after 6,9,14,17,22.
    do_start(6'b101101, 3'd6, 1'b1, 2'd0);
    expect_match(6,  2'd1, 1'b0);
    expect_match(9,  2'd2, 1'b0);
    expect_match(14, 2'd3, 1'b0);
    expect_match(17, 2'd3, 1'b0);
    expect_match(22, 2'd3, 1'b0);
    for (int w = 0; w < 3; w++) send_word(8'hB6, 8);
    // Fourth word aborted by stop after three bits.
    send_word(8'h00, 3);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    drain();
    check("t5_count_sat", match_count, 3);
    check("t5_busy", busy, 0);
    check("t5_in_ready", word_bus.in_ready, 0);
    check("t5_irq", irq, 0);
    do_start(6'b101101, 3'd6, 1'b1, 2'd0);
    check("t5_restart_count", match_count, 0);
    check("t5_restart_busy", busy, 1);

    // Reset asserted mid-SHIFT with count=3 and irq=1.
    do_start(6'b101101, 3'd6, 1'b0, 2'd3);
    expect_match(6,  2'd1, 1'b0);
    expect_match(14, 2'd2, 1'b0);
    expect_match(22, 2'd3, 1'b1);
    for (int w = 0; w < 3; w++) send_word(8'hB6, 8);
    send_word(8'hB6, 0);
    check("t6_pre_count", match_count, 3);
    check("t6_pre_irq", irq, 1);
    check("t6_pre_shift", bit_valid, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_in_ready", word_bus.in_ready, 0);
    check("t6_rst_bit_valid", bit_valid, 0);
    check("t6_rst_bit_out", bit_out, 0);
    check("t6_rst_match", match, 0);
    check("t6_rst_count", match_count, 0);
    check("t6_rst_irq", irq, 0);
    check("t6_rst_busy", busy, 0);
    #2;
    reset = 1'b1;
    repeat (3) tick();
    check("t6_post_busy", busy, 0);
    check("t6_post_in_ready", word_bus.in_ready, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
